// File: rtl/mest_pro_display_scan_pkg.sv
// Shared constants and state encoding for the display scanner.
// The OUTPUT_MEM_WIDTH value matches the 7-segment decoder's value width.
package mest_pro_display_scan_pkg;

    localparam int OUTPUT_MEM_WIDTH     = 4;
    localparam int DISPLAY_NUM_DIGITS   = 4;
    localparam int DISPLAY_SCAN_DIV     = 1000;
    localparam int DISPLAY_BLANK_CYCLES = 16;

    // Scan FSM states; the encoding is also visible on the debug state port.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/mest_pro_display_scan_lz.sv
// Leading-zero suppress mask: bit k is set when digit k and every more
// significant digit hold zero. Digit 0 is never suppressed.
module mest_pro_lz_mask #(
    parameter int MEM_WIDTH  = 4,
    parameter int NUM_DIGITS = 4
) (
    input  logic [NUM_DIGITS*MEM_WIDTH-1:0] i_bank,
    output logic [NUM_DIGITS-1:0]           o_suppress
);

    logic all_zero;

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        all_zero   = 1'b1;
        o_suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero & (i_bank[k*MEM_WIDTH +: MEM_WIDTH] == '0);
            o_suppress[k] = all_zero;
        end
    end

endmodule

// File: rtl/mest_pro_display_scan.sv
// Multiplexed display scanner: double-buffered digit bank, OFF/BLANK/SHOW
// slot sequencing, leading-zero blanking and frame-synchronous commits.
//
// Handshake: there is no valid/ready pair here. i_wr_en is a single-cycle
// write strobe always accepted; i_commit is a request that is latched into
// o_commit_pending and retired without back-pressure at the next frame
// boundary (or on the following cycle when the scanner is OFF).
module mest_pro_display_scan
    import mest_pro_display_scan_pkg::*;
#(
    parameter int MEM_WIDTH    = OUTPUT_MEM_WIDTH,
    parameter int NUM_DIGITS   = DISPLAY_NUM_DIGITS,
    parameter int SCAN_DIV     = DISPLAY_SCAN_DIV,
    parameter int BLANK_CYCLES = DISPLAY_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] i_wr_addr,
    input  logic [MEM_WIDTH-1:0]          i_wr_data,
    input  logic                          i_commit,
    output logic                          o_commit_pending,
    input  logic                          i_display_on,
    input  logic                          i_lz_suppress,
    output logic [MEM_WIDTH-1:0]          o_mem_val,
    output logic                          o_output_enable,
    output logic [NUM_DIGITS-1:0]         o_digit_sel,
    output logic                          o_frame_done,
    output logic [1:0]                    o_dbg_state
);

    localparam int AW          = $clog2(NUM_DIGITS);
    localparam int CW          = $clog2(SCAN_DIV);
    localparam int SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;

    scan_state_e           state, state_nx;
    logic [AW-1:0]         idx, idx_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  frame_end;
    logic                  apply;

    logic [MEM_WIDTH-1:0]  shadow    [NUM_DIGITS];
    logic [MEM_WIDTH-1:0]  active    [NUM_DIGITS];
    logic [MEM_WIDTH-1:0]  active_nx [NUM_DIGITS];
    logic [NUM_DIGITS*MEM_WIDTH-1:0] active_flat;
    logic [NUM_DIGITS-1:0] suppress;

    logic [MEM_WIDTH-1:0]  mem_val_nx;
    logic                  en_nx;
    logic [NUM_DIGITS-1:0] sel_nx;

    assign o_dbg_state = state;

    // Flatten the active bank for the suppress-mask block.
    always_comb begin
        active_flat = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            active_flat[k*MEM_WIDTH +: MEM_WIDTH] = active[k];
        end
    end

    // The mask only matters when entering or staying in SHOW, and the active
    // bank never changes on those edges, so the registered bank is sufficient.
    mest_pro_lz_mask #(
        .MEM_WIDTH  (MEM_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .i_bank     (active_flat),
        .o_suppress (suppress)
    );

    // Next-state logic: slot counter and digit index sequencing.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        frame_end = 1'b0;
        if (!i_display_on) begin
            state_nx = ST_OFF;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nx = ST_BLANK;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
                ST_BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_nx = ST_SHOW;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == CW'(SHOW_CYCLES - 1)) begin
                        state_nx = ST_BLANK;
                        cnt_nx   = '0;
                        if (idx == AW'(NUM_DIGITS - 1)) begin
                            idx_nx    = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Commit application and the bank value the next cycle will see.
    always_comb begin
        apply = ((state == ST_OFF) && o_commit_pending) ||
                (frame_end && (o_commit_pending || i_commit));
        for (int k = 0; k < NUM_DIGITS; k++) begin
            active_nx[k] = apply ? shadow[k] : active[k];
        end
    end

    // Registered-output values; digit select trails enable by one cycle and
    // is cut as soon as the slot leaves SHOW.
    always_comb begin
        mem_val_nx = '0;
        en_nx      = 1'b0;
        sel_nx     = '0;
        if (state_nx != ST_OFF) begin
            mem_val_nx = active_nx[idx_nx];
        end
        if (state_nx == ST_SHOW) begin
            en_nx = !(i_lz_suppress && suppress[idx_nx]);
            if (o_output_enable) begin
                sel_nx = NUM_DIGITS'(1) << idx;
            end
        end
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_OFF;
            idx              <= '0;
            cnt              <= '0;
            o_mem_val        <= '0;
            o_output_enable  <= 1'b0;
            o_digit_sel      <= '0;
            o_frame_done     <= 1'b0;
            o_commit_pending <= 1'b0;
        end else begin
            state            <= state_nx;
            idx              <= idx_nx;
            cnt              <= cnt_nx;
            o_mem_val        <= mem_val_nx;
            o_output_enable  <= en_nx;
            o_digit_sel      <= sel_nx;
            o_frame_done     <= frame_end;
            o_commit_pending <= apply ? 1'b0 : (o_commit_pending | i_commit);
        end
    end

    // Shadow writes and active-bank copy; a write on the copy edge only
    // reaches the shadow, so the copy sees the pre-write value.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                active[k] <= active_nx[k];
            end
            if (i_wr_en && (int'(i_wr_addr) < NUM_DIGITS)) begin
                shadow[i_wr_addr] <= i_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_mest_pro_display_scan.sv
// Self-checking bench for mest_pro_display_scan (4 digits, 8-cycle slots,
// 2 blank cycles). A time-based reference model predicts every output.
module tb_mest_pro_display_scan;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int B     = 2;
    localparam int FRAME = N * SD;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [1:0] i_wr_addr = '0;
    logic [3:0] i_wr_data = '0;
    logic       i_commit = 1'b0;
    logic       i_display_on = 1'b0;
    logic       i_lz_suppress = 1'b0;
    logic       o_commit_pending;
    logic [3:0] o_mem_val;
    logic       o_output_enable;
    logic [3:0] o_digit_sel;
    logic       o_frame_done;
    logic [1:0] o_dbg_state;

    always #5 clk = ~clk;

    mest_pro_display_scan #(
        .MEM_WIDTH    (4),
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (B)
    ) dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_wr_en          (i_wr_en),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_commit         (i_commit),
        .o_commit_pending (o_commit_pending),
        .i_display_on     (i_display_on),
        .i_lz_suppress    (i_lz_suppress),
        .o_mem_val        (o_mem_val),
        .o_output_enable  (o_output_enable),
        .o_digit_sel      (o_digit_sel),
        .o_frame_done     (o_frame_done),
        .o_dbg_state      (o_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The display is described by elapsed time t since scanning began:
    // slot = (t / SD) % N, position in slot = t % SD.
    int m_active[N];
    int m_shadow[N];
    bit m_pend, m_on, m_prev_en;
    int m_t;
    int e_mem, e_sel, e_state;
    bit e_en, e_fd;
    bit cur_on, cur_lz;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_active[k] = 0;
            m_shadow[k] = 0;
        end
        m_pend = 0; m_on = 0; m_prev_en = 0; m_t = 0;
        e_mem = 0; e_sel = 0; e_state = 0; e_en = 0; e_fd = 0;
    endtask

    function automatic bit m_supp(input int k);
        int msd;
        if (!i_lz_suppress) return 1'b0;
        msd = 0;
        for (int j = 0; j < N; j++) if (m_active[j] != 0) msd = j;
        return k > msd;
    endfunction

    task automatic model_edge();
        bit was_on, fe, apply;
        int slot, pos;
        was_on = m_on;
        fe     = 0;
        if (!i_display_on) begin
            m_on = 0;
        end else if (!was_on) begin
            m_on = 1;
            m_t  = 0;
        end else begin
            m_t++;
            fe = (m_t % FRAME) == 0;
        end
        apply = (!was_on && m_pend) || (fe && (m_pend || i_commit));
        if (apply) m_active = m_shadow;
        m_pend = apply ? 1'b0 : (m_pend | i_commit);
        if (i_wr_en) m_shadow[i_wr_addr] = int'(i_wr_data);
        if (m_on) begin
            slot    = (m_t / SD) % N;
            pos     = m_t % SD;
            e_mem   = m_active[slot];
            e_en    = (pos >= B) && !m_supp(slot);
            e_sel   = (pos >= B + 1 && m_prev_en) ? (1 << slot) : 0;
            e_fd    = fe;
            e_state = (pos >= B) ? 2 : 1;
        end else begin
            e_mem = 0; e_en = 0; e_sel = 0; e_fd = 0; e_state = 0;
        end
        m_prev_en = e_en;
    endtask

    task automatic compare_all();
        chk("mem_val", o_mem_val, e_mem);
        chk("output_enable", o_output_enable, e_en);
        chk("digit_sel", o_digit_sel, e_sel);
        chk("frame_done", o_frame_done, e_fd);
        chk("commit_pending", o_commit_pending, m_pend);
        chk("state", o_dbg_state, e_state);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit we, input int addr, input int data, input bit cm,
                        input bit on, input bit lz);
        @(negedge clk);
        i_wr_en       = we;
        i_wr_addr     = addr[1:0];
        i_wr_data     = data[3:0];
        i_commit      = cm;
        i_display_on  = on;
        i_lz_suppress = lz;
        cur_on = on;
        cur_lz = lz;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, cur_on, cur_lz);
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (!(m_on && m_t == target) && n < 300) begin
            idle();
            n++;
        end
        chk("run_to_t", m_t, target);
    endtask

    // ---------------- table of leading-zero vectors ----------------
    typedef struct {
        logic [15:0] bank;      // digit 3..0 nibbles
        logic        lz;
        logic [3:0]  exp_mask;  // digits that light up during a frame
    } lz_vec_t;

    lz_vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs, en_cnt;
        vecs[0] = '{bank: 16'h4321, lz: 1'b1, exp_mask: 4'b1111};
        vecs[1] = '{bank: 16'h0500, lz: 1'b1, exp_mask: 4'b0111};
        vecs[2] = '{bank: 16'h0000, lz: 1'b1, exp_mask: 4'b0001};
        vecs[3] = '{bank: 16'h0000, lz: 1'b0, exp_mask: 4'b1111};
        vecs[4] = '{bank: 16'h0003, lz: 1'b1, exp_mask: 4'b0001};
        vecs[5] = '{bank: 16'h0090, lz: 1'b1, exp_mask: 4'b0011};
        vecs[6] = '{bank: 16'h1000, lz: 1'b1, exp_mask: 4'b1111};

        model_reset();
        cur_on = 0; cur_lz = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_mem_val", o_mem_val, 0);
        chk("reset_enable", o_output_enable, 0);
        chk("reset_sel", o_digit_sel, 0);
        chk("reset_pending", o_commit_pending, 0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Basic scan: 1,2,3,4 committed while OFF.
        for (int k = 0; k < N; k++) step(1, k, k + 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("pending_after_commit", o_commit_pending, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("pending_applied_off", o_commit_pending, 0);
        step(0, 0, 0, 0, 1, 0);                      // t = 0: first BLANK cycle
        chk("blank_enable_t0", o_output_enable, 0);
        for (int t = 1; t <= FRAME + 1; t++) begin
            idle();
            if (t % SD == B && t < FRAME) begin
                chk("first_show_enable", o_output_enable, 1);
                chk("first_show_val", o_mem_val, (t / SD) + 1);
                chk("align_sel_zero", o_digit_sel, 0);
            end
            if (t % SD == B + 1 && t < FRAME)
                chk("sel_onehot", o_digit_sel, 1 << (t / SD));
            if (t == FRAME) chk("frame_done_pulse", o_frame_done, 1);
            if (t == FRAME + 1) chk("frame_done_once", o_frame_done, 0);
        end

        // Mid-frame write with commit: digit 0 keeps showing 1 until frame end.
        run_to(FRAME + 1);
        step(1, 0, 9, 1, 1, 0);                      // t = 34
        chk("pending_midframe", o_commit_pending, 1);
        for (int t = 35; t < 40; t++) begin
            idle();
            chk("old_digit0_val", o_mem_val, 1);
        end
        run_to(2 * FRAME - 1);
        chk("pending_before_end", o_commit_pending, 1);
        idle();                                      // t = 64
        chk("commit_frame_done", o_frame_done, 1);
        chk("commit_cleared", o_commit_pending, 0);
        chk("new_digit0_blank", o_mem_val, 9);
        run_to(2 * FRAME + B);
        chk("new_digit0_show", o_mem_val, 9);

        // Write on the commit-apply edge: copy takes the old shadow value.
        step(1, 1, 6, 1, 1, 0);                      // t = 67
        run_to(3 * FRAME - 1);
        step(1, 0, 7, 0, 1, 0);                      // t = 96, apply edge
        chk("apply_fd", o_frame_done, 1);
        chk("apply_old_shadow", o_mem_val, 9);
        run_to(3 * FRAME + SD + B);
        chk("apply_digit1", o_mem_val, 6);
        step(0, 0, 0, 1, 1, 0);
        run_to(4 * FRAME);
        chk("second_commit_val", o_mem_val, 7);

        // Leading-zero table.
        step(0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            for (int k = 0; k < N; k++)
                step(1, k, int'(vecs[i].bank[k*4 +: 4]), 0, 0, vecs[i].lz);
            step(0, 0, 0, 1, 0, vecs[i].lz);
            step(0, 0, 0, 0, 0, vecs[i].lz);
            step(0, 0, 0, 0, 1, vecs[i].lz);         // t = 0
            obs = 0;
            en_cnt = 0;
            for (int t = 1; t < FRAME; t++) begin
                idle();
                obs = obs | int'(o_digit_sel);
                en_cnt = en_cnt + int'(o_output_enable);
            end
            chk("lz_mask", obs, vecs[i].exp_mask);
            chk("lz_enable_cycles", en_cnt, 6 * $countones(vecs[i].exp_mask));
            step(0, 0, 0, 0, 0, vecs[i].lz);
        end

        // Drop the display during SHOW of digit 2, then restart.
        step(0, 0, 0, 0, 1, 0);
        run_to(2 * SD + B + 2);
        step(0, 0, 0, 0, 0, 0);
        chk("drop_enable", o_output_enable, 0);
        chk("drop_sel", o_digit_sel, 0);
        chk("drop_state_off", o_dbg_state, 0);
        step(0, 0, 0, 0, 1, 0);                      // t = 0
        idle();
        chk("restart_blank", o_output_enable, 0);
        idle();                                      // t = 2
        chk("restart_enable", o_output_enable, 1);
        chk("restart_align", o_digit_sel, 0);
        idle();
        chk("restart_sel", o_digit_sel, 4'b0001);

        // Asynchronous reset in the middle of a SHOW cycle.
        run_to(SD + B);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_enable", o_output_enable, 0);
        chk("async_rst_mem", o_mem_val, 0);
        chk("async_rst_sel", o_digit_sel, 0);
        chk("async_rst_fd", o_frame_done, 0);
        chk("async_rst_state", o_dbg_state, 0);
        model_reset();
        @(negedge clk);
        i_display_on = 0; i_commit = 0; i_wr_en = 0;
        cur_on = 0; cur_lz = 0;
        @(negedge clk);
        i_rst_n = 1'b1;
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int t = 1; t < FRAME; t++) begin
            idle();
            if (t % SD == B) chk("bank_zero_after_reset", o_mem_val, 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit we, cm, on, lz;
            we = ($urandom_range(0, 99) < 30);
            cm = ($urandom_range(0, 99) < 8);
            on = ($urandom_range(0, 99) < 3) ? !cur_on : cur_on;
            lz = ($urandom_range(0, 99) < 4) ? !cur_lz : cur_lz;
            if (n == 0) on = 1;
            step(we, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)), cm, on, lz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
